// File: rtl/gate_truth_table_checker_if.sv
// Control, status and gate-under-test signals shared between the checker and its environment.
interface gate_truth_table_checker_if;
    logic       start;
    logic [1:0] func_sel;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        input  start, func_sel, dut_c,
        output dut_a, dut_b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, func_sel, dut_c,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps all four {a,b} vectors into a 2-input gate and compares its settled
// output against the selected function (AND/OR/XOR/NAND).
module gate_truth_table_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gate_truth_table_checker_if.master    bus
);
    localparam int unsigned TW = 4;
    localparam int unsigned EW = 3;

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    state_t          r_state, w_state_n;
    logic [1:0]      r_vec, w_vec_n;
    logic [TW-1:0]   r_timer, w_timer_n;
    logic [1:0]      r_func, w_func_n;
    logic            r_dut_a, w_dut_a_n;
    logic            r_dut_b, w_dut_b_n;
    logic [EW-1:0]   r_err, w_err_n;
    logic [3:0]      r_fail, w_fail_n;
    logic            r_pass, w_pass_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic            w_exp;

    // Expected gate output for the vector currently on dut_a/dut_b
    always_comb begin
        w_exp = 1'b0;
        case (r_func)
            2'b00:   w_exp = r_dut_a & r_dut_b;
            2'b01:   w_exp = r_dut_a | r_dut_b;
            2'b10:   w_exp = r_dut_a ^ r_dut_b;
            default: w_exp = ~(r_dut_a & r_dut_b);
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_vec_n   = r_vec;
        w_timer_n = r_timer;
        w_func_n  = r_func;
        w_dut_a_n = r_dut_a;
        w_dut_b_n = r_dut_b;
        w_err_n   = r_err;
        w_fail_n  = r_fail;
        w_pass_n  = r_pass;

        case (r_state)
            IDLE: begin
                w_dut_a_n = 1'b0;
                w_dut_b_n = 1'b0;
                if (bus.start) begin
                    w_state_n = DRIVE;
                    w_func_n  = bus.func_sel;
                    w_vec_n   = 2'd0;
                    w_err_n   = '0;
                    w_fail_n  = '0;
                    w_pass_n  = 1'b0;
                end
            end
            DRIVE: begin
                w_dut_a_n = r_vec[1];
                w_dut_b_n = r_vec[0];
                w_timer_n = TW'(SETTLE - 1);
                w_state_n = WAIT;
            end
            WAIT: begin
                if (r_timer == '0) begin
                    w_state_n = CHECK;
                end else begin
                    w_timer_n = r_timer - TW'(1);
                end
            end
            CHECK: begin
                if (bus.dut_c != w_exp) begin
                    if (r_err < EW'(4)) begin
                        w_err_n = r_err + EW'(1);
                    end
                    w_fail_n[r_vec] = 1'b1;
                end
                if (r_vec == 2'd3) begin
                    w_state_n = DONE;
                    w_dut_a_n = 1'b0;
                    w_dut_b_n = 1'b0;
                    w_pass_n  = (w_err_n == '0);
                end else begin
                    w_vec_n   = r_vec + 2'd1;
                    w_state_n = DRIVE;
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they align with it
        w_busy_n = (w_state_n == DRIVE) || (w_state_n == WAIT) || (w_state_n == CHECK);
        w_done_n = (w_state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_timer <= '0;
            r_func  <= '0;
            r_dut_a <= 1'b0;
            r_dut_b <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_vec   <= w_vec_n;
            r_timer <= w_timer_n;
            r_func  <= w_func_n;
            r_dut_a <= w_dut_a_n;
            r_dut_b <= w_dut_b_n;
            r_err   <= w_err_n;
            r_fail  <= w_fail_n;
            r_pass  <= w_pass_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign bus.dut_a     = r_dut_a;
    assign bus.dut_b     = r_dut_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_vec  = r_fail;
endmodule
